// File: rtl/exec_writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : exec_writeback_stage_if
// Brief    : Decoded-instruction, status and debug bundle for the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
interface exec_writeback_stage_if #(
    parameter int DATA_W = 16
);
    logic [3:0]        opcode;
    logic              source2_select;
    logic              alu_out_select;
    logic              regwrite_flag;
    logic [5:0]        immediate_addr;
    logic [2:0]        rreg_sig1;
    logic [2:0]        rreg_sig2;
    logic [2:0]        wreg_sig;
    logic              stall;
    logic [DATA_W-1:0] result;
    logic              zero_flag;
    logic              neg_flag;
    logic              carry_flag;
    logic [2:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output opcode, source2_select, alu_out_select, regwrite_flag,
               immediate_addr, rreg_sig1, rreg_sig2, wreg_sig, dbg_addr,
        input  stall, result, zero_flag, neg_flag, carry_flag, dbg_data
    );

    modport slave (
        input  opcode, source2_select, alu_out_select, regwrite_flag,
               immediate_addr, rreg_sig1, rreg_sig2, wreg_sig, dbg_addr,
        output stall, result, zero_flag, neg_flag, carry_flag, dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/exec_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : exec_writeback_stage
// Brief    : Register file, ID/EX register, ALU and writeback with EX bypass.
//            Define MUL_EN to add the multi-cycle shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module exec_writeback_stage #(
    parameter int DATA_W     = 16,
    parameter int MUL_CYCLES = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    exec_writeback_stage_if.slave bus
);
    localparam logic [3:0] c_op_add = 4'd0;
    localparam logic [3:0] c_op_sub = 4'd1;
    localparam logic [3:0] c_op_and = 4'd2;
    localparam logic [3:0] c_op_or  = 4'd3;
    localparam logic [3:0] c_op_xor = 4'd4;
    localparam logic [3:0] c_op_sll = 4'd5;
    localparam logic [3:0] c_op_srl = 4'd6;
    localparam logic [3:0] c_op_not = 4'd7;

    logic [DATA_W-1:0] r_regs [8];
    logic [DATA_W-1:0] r_ex_a;
    logic [DATA_W-1:0] r_ex_b;
    logic [3:0]        r_ex_op;
    logic              r_ex_sel;
    logic [5:0]        r_ex_imm;
    logic [2:0]        r_ex_wreg;
    logic              r_ex_we;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_neg;
    logic              r_carry;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_carry;
    logic [DATA_W-1:0] w_ex_val;
    logic              w_ex_carry;
    logic              w_ex_fwd;
    logic              w_ex_is_mul;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic              w_stall;
    logic              w_mul_done;
    logic              w_mul_wr;
    logic [DATA_W-1:0] w_mul_val;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_wr_val;
    logic              w_wr_carry;

    always_comb begin
        w_sum       = '0;
        w_alu_res   = r_ex_b;
        w_alu_carry = 1'b0;
        case (r_ex_op)
            c_op_add: begin
                w_sum       = {1'b0, r_ex_a} + {1'b0, r_ex_b};
                w_alu_res   = w_sum[DATA_W-1:0];
                w_alu_carry = w_sum[DATA_W];
            end
            c_op_sub: begin
                // Bit DATA_W of the widened difference is the borrow (A < B).
                w_sum       = {1'b0, r_ex_a} - {1'b0, r_ex_b};
                w_alu_res   = w_sum[DATA_W-1:0];
                w_alu_carry = w_sum[DATA_W];
            end
            c_op_and: w_alu_res = r_ex_a & r_ex_b;
            c_op_or:  w_alu_res = r_ex_a | r_ex_b;
            c_op_xor: w_alu_res = r_ex_a ^ r_ex_b;
            c_op_sll: w_alu_res = r_ex_a << r_ex_b[3:0];
            c_op_srl: w_alu_res = r_ex_a >> r_ex_b[3:0];
            c_op_not: w_alu_res = ~r_ex_a;
            default:  w_alu_res = r_ex_b;
        endcase
    end

    assign w_ex_val   = r_ex_sel ? {{(DATA_W-6){1'b0}}, r_ex_imm} : w_alu_res;
    assign w_ex_carry = r_ex_sel ? 1'b0 : w_alu_carry;
    assign w_ex_fwd   = r_ex_we && (r_ex_wreg != 3'd0) && !w_ex_is_mul;

    always_comb begin
        w_op_a = r_regs[bus.rreg_sig1];
        if (w_ex_fwd && (r_ex_wreg == bus.rreg_sig1)) begin
            w_op_a = w_ex_val;
        end
        w_op_b = r_regs[bus.rreg_sig2];
        if (w_ex_fwd && (r_ex_wreg == bus.rreg_sig2)) begin
            w_op_b = w_ex_val;
        end
        if (bus.source2_select) begin
            w_op_b = {{(DATA_W-6){1'b0}}, bus.immediate_addr};
        end
    end

    always_comb begin
        w_wr_en    = w_ex_fwd;
        w_wr_val   = w_ex_val;
        w_wr_carry = w_ex_carry;
        if (w_mul_wr) begin
            w_wr_en    = 1'b1;
            w_wr_val   = w_mul_val;
            w_wr_carry = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
            r_ex_a    <= '0;
            r_ex_b    <= '0;
            r_ex_op   <= '0;
            r_ex_sel  <= 1'b0;
            r_ex_imm  <= '0;
            r_ex_wreg <= '0;
            r_ex_we   <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
            r_carry   <= 1'b0;
        end else begin
            if (!w_stall) begin
                r_ex_a    <= w_op_a;
                r_ex_b    <= w_op_b;
                r_ex_op   <= bus.opcode;
                r_ex_sel  <= bus.alu_out_select;
                r_ex_imm  <= bus.immediate_addr;
                r_ex_wreg <= bus.wreg_sig;
                r_ex_we   <= bus.regwrite_flag;
            end else if (w_mul_done) begin
                // Retire the multiply so it neither bypasses nor writes again.
                r_ex_we <= 1'b0;
            end
            if (w_wr_en) begin
                r_regs[r_ex_wreg] <= w_wr_val;
                r_result          <= w_wr_val;
                r_zero            <= (w_wr_val == '0);
                r_neg             <= w_wr_val[DATA_W-1];
                r_carry           <= w_wr_carry;
            end
        end
    end

`ifdef MUL_EN
    localparam logic [3:0] c_op_mul = 4'd8;
    localparam int         c_cnt_w  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MUL_CYCLES - 1);
    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_busy = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic               r_stall;
    logic               w_stall_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [DATA_W-1:0]  r_mul_acc;
    logic [DATA_W-1:0]  r_mul_a;
    logic [DATA_W-1:0]  r_mul_b;
    logic [DATA_W-1:0]  w_mul_acc_nxt;
    logic               w_mul_start;

    assign w_ex_is_mul   = (r_ex_op == c_op_mul);
    assign w_mul_start   = !r_stall && (bus.opcode == c_op_mul);
    assign w_mul_done    = (r_state == c_st_busy) && (r_cnt == c_cnt_last);
    assign w_mul_acc_nxt = r_mul_acc + (r_mul_b[0] ? r_mul_a : '0);
    assign w_mul_wr      = w_mul_done && r_ex_we && (r_ex_wreg != 3'd0);
    assign w_mul_val     = w_mul_acc_nxt;
    assign w_stall       = r_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_stall <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_stall <= w_stall_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall_nxt = r_stall;
        case (r_state)
            c_st_idle: begin
                if (w_mul_start) begin
                    w_state_nxt = c_st_busy;
                    w_stall_nxt = 1'b1;
                end
            end
            default: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_st_idle;
                    w_stall_nxt = 1'b0;
                end
            end
        endcase
    end

    // One multiplier bit per cycle; operands are latched alongside EX capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_mul_acc <= '0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
        end else if (w_mul_start) begin
            r_cnt     <= '0;
            r_mul_acc <= '0;
            r_mul_a   <= w_op_a;
            r_mul_b   <= w_op_b;
        end else if (r_state == c_st_busy) begin
            r_cnt     <= r_cnt + 1'b1;
            r_mul_acc <= w_mul_acc_nxt;
            r_mul_a   <= r_mul_a << 1;
            r_mul_b   <= r_mul_b >> 1;
        end
    end
`else
    assign w_ex_is_mul = 1'b0;
    assign w_mul_done  = 1'b0;
    assign w_mul_wr    = 1'b0;
    assign w_mul_val   = '0;
    assign w_stall     = 1'b0;
`endif

    assign bus.stall      = w_stall;
    assign bus.result     = r_result;
    assign bus.zero_flag  = r_zero;
    assign bus.neg_flag   = r_neg;
    assign bus.carry_flag = r_carry;
    assign bus.dbg_data   = (bus.dbg_addr == 3'd0) ? '0 : r_regs[bus.dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_exec_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_writeback_stage
// Brief    : Directed and random stimulus against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_writeback_stage;
    localparam int MULC = 16;
`ifdef MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   stall_seen;

    exec_writeback_stage_if #(.DATA_W(16)) bus ();

    exec_writeback_stage #(.DATA_W(16), .MUL_CYCLES(MULC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Architectural state (every issued instruction applied at once) and the
    // state the DUT should expose right now (lagging by its commit latency).
    logic [15:0] m_arch [8];
    logic [15:0] m_vis  [8];
    logic [15:0] a_res, v_res;
    logic        a_z, a_n, a_c, v_z, v_n, v_c;
    int          busy;

    logic [3:0] cur_op;
    logic       cur_s2, cur_osel, cur_we;
    logic [5:0] cur_imm;
    logic [2:0] cur_r1, cur_r2, cur_wr;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_arch[i] = '0;
            m_vis[i]  = '0;
        end
        a_res = '0; a_z = 0; a_n = 0; a_c = 0;
        v_res = '0; v_z = 0; v_n = 0; v_c = 0;
        busy  = 0;
    endtask

    task automatic model_publish();
        for (int i = 0; i < 8; i++) m_vis[i] = m_arch[i];
        v_res = a_res; v_z = a_z; v_n = a_n; v_c = a_c;
    endtask

    task automatic model_apply();
        int          a, b, v;
        logic        c;
        longint      prod;
        a = int'(m_arch[cur_r1]);
        b = cur_s2 ? int'(cur_imm) : int'(m_arch[cur_r2]);
        c = 1'b0;
        case (cur_op)
            4'd0: begin v = (a + b) % 65536; c = (a + b) >= 65536; end
            4'd1: begin v = (a - b + 65536) % 65536; c = (a < b); end
            4'd2: v = a & b;
            4'd3: v = a | b;
            4'd4: v = a ^ b;
            4'd5: v = (a * (1 << (b % 16))) % 65536;
            4'd6: v = a / (1 << (b % 16));
            4'd7: v = 65535 - a;
            default: v = b;
        endcase
        if (MUL_ON && cur_op == 4'd8) begin
            prod = longint'(a) * longint'(b);
            v = int'(prod % 65536);
            c = 1'b0;
        end else if (cur_osel) begin
            v = int'(cur_imm);
            c = 1'b0;
        end
        if (cur_we && cur_wr != 3'd0) begin
            m_arch[cur_wr] = 16'(v);
            a_res = 16'(v);
            a_z   = (v == 0);
            a_n   = (v >= 32768);
            a_c   = c;
        end
        if (MUL_ON && cur_op == 4'd8) busy = MULC;
    endtask

    task automatic model_edge(output bit acc);
        acc = 1'b0;
        if (busy > 0) begin
            busy--;
            if (busy == 0) model_publish();
        end else begin
            model_publish();
            model_apply();
            acc = 1'b1;
        end
    endtask

    task automatic tick(output bit acc);
        bus.opcode         = cur_op;
        bus.source2_select = cur_s2;
        bus.alu_out_select = cur_osel;
        bus.regwrite_flag  = cur_we;
        bus.immediate_addr = cur_imm;
        bus.rreg_sig1      = cur_r1;
        bus.rreg_sig2      = cur_r2;
        bus.wreg_sig       = cur_wr;
        bus.dbg_addr       = 3'($urandom_range(0, 7));
        @(posedge clk);
        model_edge(acc);
        #1;
        check("stall", bus.stall, busy > 0);
        check("result", bus.result, v_res);
        check("zero", bus.zero_flag, v_z);
        check("neg", bus.neg_flag, v_n);
        check("carry", bus.carry_flag, v_c);
        check("dbg_data", bus.dbg_data, m_vis[bus.dbg_addr]);
        if (bus.stall) stall_seen++;
    endtask

    task automatic issue(input logic [3:0] op, input logic s2, input logic osel,
                         input logic we, input logic [5:0] imm, input logic [2:0] r1,
                         input logic [2:0] r2, input logic [2:0] wr);
        bit acc;
        cur_op = op; cur_s2 = s2; cur_osel = osel; cur_we = we;
        cur_imm = imm; cur_r1 = r1; cur_r2 = r2; cur_wr = wr;
        for (int k = 0; k < MULC + 4; k++) begin
            tick(acc);
            if (acc) break;
        end
    endtask

    task automatic nop();
        issue(4'd0, 1'b0, 1'b0, 1'b0, 6'd0, 3'd0, 3'd0, 3'd0);
    endtask

    task automatic read_reg(input logic [2:0] idx, output logic [15:0] d);
        bus.dbg_addr = idx;
        #1;
        d = bus.dbg_data;
    endtask

    task automatic reset_and_check(input string tag);
        logic [15:0] d;
        rst = 1'b1;
        #1;
        check({tag, "_stall"}, bus.stall, 16'd0);
        check({tag, "_result"}, bus.result, 16'd0);
        check({tag, "_flags"}, {bus.zero_flag, bus.neg_flag, bus.carry_flag}, 16'd0);
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), d);
            check({tag, "_reg"}, d, 16'd0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        bit          acc;
        checks = 0; errors = 0; stall_seen = 0;
        rst = 1'b0;
        cur_op = '0; cur_s2 = 0; cur_osel = 0; cur_we = 0;
        cur_imm = '0; cur_r1 = '0; cur_r2 = '0; cur_wr = '0;
        bus.opcode = '0; bus.source2_select = 0; bus.alu_out_select = 0;
        bus.regwrite_flag = 0; bus.immediate_addr = '0; bus.rreg_sig1 = '0;
        bus.rreg_sig2 = '0; bus.wreg_sig = '0; bus.dbg_addr = '0;
        #2;
        reset_and_check("por");

        // Load-immediate lands two edges after decode.
        issue(4'd9, 0, 1, 1, 6'h2A, 3'd0, 3'd0, 3'd3);
        nop();
        read_reg(3'd3, d);
        check("li_r3", d, 16'h002A);
        check("li_zn", {bus.zero_flag, bus.neg_flag}, 16'd0);

        // Back-to-back dependent ADD/SUB through the bypass.
        issue(4'd9, 0, 1, 1, 6'd5, 3'd0, 3'd0, 3'd1);
        issue(4'd9, 0, 1, 1, 6'd7, 3'd0, 3'd0, 3'd2);
        issue(4'd0, 0, 0, 1, 6'd0, 3'd1, 3'd2, 3'd3);
        issue(4'd1, 0, 0, 1, 6'd0, 3'd3, 3'd1, 3'd4);
        nop();
        read_reg(3'd3, d);
        check("bypass_r3", d, 16'd12);
        read_reg(3'd4, d);
        check("bypass_r4", d, 16'd7);
        check("sub_nb_carry", bus.carry_flag, 16'd0);
        issue(4'd1, 0, 0, 1, 6'd0, 3'd1, 3'd2, 3'd5);
        nop();
        check("sub_borrow_res", bus.result, 16'hFFFE);
        check("sub_borrow_nc", {bus.neg_flag, bus.carry_flag}, 16'd3);

        // r0 writes and regwrite_flag=0 leave everything untouched.
        issue(4'd0, 0, 0, 1, 6'd0, 3'd1, 3'd2, 3'd0);
        nop();
        read_reg(3'd0, d);
        check("r0_zero", d, 16'd0);
        check("r0_result", bus.result, 16'hFFFE);
        check("r0_flags", {bus.zero_flag, bus.neg_flag, bus.carry_flag}, 16'd3);
        issue(4'd0, 0, 0, 0, 6'd0, 3'd1, 3'd2, 3'd5);
        nop();
        read_reg(3'd5, d);
        check("nowe_r5", d, 16'hFFFE);
        check("nowe_result", bus.result, 16'hFFFE);

        // Wrap-around add and full-width shift.
        issue(4'd1, 1, 0, 1, 6'd1, 3'd0, 3'd0, 3'd6);
        issue(4'd0, 1, 0, 1, 6'd1, 3'd6, 3'd0, 3'd7);
        nop();
        check("wrap_result", bus.result, 16'd0);
        check("wrap_zc", {bus.zero_flag, bus.carry_flag}, 16'd3);
        issue(4'd9, 0, 1, 1, 6'd1, 3'd0, 3'd0, 3'd1);
        issue(4'd5, 1, 0, 1, 6'd15, 3'd1, 3'd0, 3'd2);
        nop();
        read_reg(3'd2, d);
        check("sll_r2", d, 16'h8000);
        check("sll_nc", {bus.neg_flag, bus.carry_flag}, 16'd2);

        issue(4'd0, 0, 0, 1, 6'd0, 3'd1, 3'd2, 3'd3);
        reset_and_check("mid");

`ifdef MUL_EN
        issue(4'd9, 0, 1, 1, 6'd18, 3'd0, 3'd0, 3'd1);
        issue(4'd5, 1, 0, 1, 6'd4, 3'd1, 3'd0, 3'd1);
        issue(4'd0, 1, 0, 1, 6'd12, 3'd1, 3'd0, 3'd1);
        issue(4'd0, 1, 0, 1, 6'd0, 3'd1, 3'd0, 3'd2);
        stall_seen = 0;
        issue(4'd8, 0, 0, 1, 6'd0, 3'd1, 3'd2, 3'd3);
        issue(4'd0, 1, 0, 1, 6'd1, 3'd3, 3'd0, 3'd4);
        nop();
        read_reg(3'd3, d);
        check("mul_r3", d, 16'h5F90);
        read_reg(3'd4, d);
        check("mul_dep_r4", d, 16'h5F91);
        check("mul_stall_len", 16'(stall_seen), 16'd16);
        issue(4'd8, 0, 0, 1, 6'd0, 3'd1, 3'd2, 3'd3);
        cur_op = 4'd0; cur_we = 1'b0;
        for (int k = 0; k < 4; k++) tick(acc);
        reset_and_check("mulrst");
`endif

        for (int n = 0; n < 250; n++) begin
            logic [3:0] op;
            logic       osel;
            op   = 4'($urandom_range(0, 15));
            osel = ($urandom_range(0, 3) == 0);
            if (MUL_ON && op == 4'd8) osel = 1'b0;
            issue(op, 1'($urandom_range(0, 1)), osel, ($urandom_range(0, 7) != 0),
                  6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        nop();
        nop();
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), d);
            check("final_reg", d, m_vis[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/exec_writeback_stage.md
Name: exec_writeback_stage

Overview:
- Datapath stage directly downstream of the 16-bit processor's control/decode logic.
- Consumes the decoded fields each cycle (opcode, source-2 select, ALU-out select, write flag, immediate, read/write register indices).
- Contains the 8x16 register file, an ID/EX pipeline register, the ALU, a result register and a status-flag register.
- Writes results back at the end of the execute cycle and forwards them to dependent instructions; optional multi-cycle multiply stalls upstream.

Parameters:
- DATA_W, 16, datapath width
- MUL_CYCLES, 16, execute cycles for MUL (used only with MUL_EN)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- opcode  input  4  decoded ALU opcode
- source2_select  input  1  0: operand B = reg[rreg_sig2]; 1: operand B = zero-extended immediate_addr
- alu_out_select  input  1  0: write ALU result; 1: write zero-extended immediate_addr
- regwrite_flag  input  1  instruction writes wreg_sig
- immediate_addr  input  6  immediate field
- rreg_sig1  input  3  source register A index
- rreg_sig2  input  3  source register B index
- wreg_sig  input  3  destination index
- stall  output  1  registered; upstream must hold PC/IR while high
- result  output  DATA_W  registered last written-back value
- zero_flag, neg_flag, carry_flag  output  1 each  registered status
- dbg_addr  input  3  debug read index
- dbg_data  output  DATA_W  combinational reg[dbg_addr], r0 reads 0

Behaviour:
- Reset (async, rst=1):
  - all registers, EX register, result and flags clear to 0; EX write-enable = 0.
  - stall = 0; FSM = IDLE.
  - a reset mid-multiply abandons it with no write.
- Register file:
  - r0 reads 0; writes to r0 are dropped and do not update result or flags.
  - reads are combinational.
- Decode cycle N (stall=0), read operands:
  - A = reg[rreg_sig1]; B = reg[rreg_sig2] or zero-extended immediate.
  - EX bypass: if the EX stage writes a nonzero index equal to a read index, use the current EX write value instead of reg[].
- EX capture: at the edge ending cycle N, the EX register captures A, B, opcode, alu_out_select, wreg_sig, and we = regwrite_flag. It does not capture while stall=1.
- Execute cycle N+1:
  - ALU is combinational on the EX register.
  - At the edge ending N+1, if we and wreg≠0: write reg[wreg], result <= value, update flags.
  - Latency from decode to register write is 2 edges; a back-to-back dependent instruction sees the value via the bypass.
- ALU opcodes, all modulo 2^16:
  - 0 ADD: carry = carry-out.
  - 1 SUB (A-B): carry = borrow, i.e. A<B unsigned.
  - 2 AND, 3 OR, 4 XOR, 7 NOT A.
  - 5 SLL A by B[3:0], 6 SRL A by B[3:0].
  - 8 MUL (see option).
  - 9-15 pass B.
  - Carry is 0 for every opcode except ADD/SUB.
- Write value: zero-extended immediate when alu_out_select=1 (flags computed on it, carry 0), else the ALU result.
- Flags: zero = (value==0), neg = value[15]; they change only on a performed write.

Optional Feature:
- Macro: MUL_EN.
- Defined, capture of MUL:
  - Capture of opcode 8 moves the FSM IDLE→BUSY and stall is registered 1 from the next cycle (cycle M).
  - The shift-add unit runs MUL_CYCLES cycles (M..M+MUL_CYCLES-1); low 16 bits are written at the edge ending M+MUL_CYCLES-1.
  - FSM→IDLE; stall=0 from cycle M+MUL_CYCLES.
- Defined, behaviour while BUSY:
  - no EX capture and no bypass from MUL.
  - the held instruction is captured at the first edge with stall=0 and reads the product from the register file.
  - carry=0.
- Undefined: opcode 8 = pass B; stall tied 0; no FSM.

Test Plan:
- Reset: assert rst mid-stream -> all dbg_data reads 0, result=0, flags=0, stall=0 immediately without a clock.
- Load-immediate: opcode=9, alu_out_select=1, imm=6'h2A, wreg=3 -> reg3=16'h002A two edges later, zero=0, neg=0.
- Back-to-back: r1=5, r2=7, then ADD r3=r1+r2 followed immediately by SUB r4=r3-r1 -> r3=12 via bypass, r4=7, carry=0; then SUB r5=r1-r2 -> 16'hFFFE, neg=1, carry=1.
- r0 and write gating: ADD wreg=0 -> r0 still 0, flags unchanged; regwrite_flag=0 -> no register, result or flag change.
- Shift and wrap: ADD 16'hFFFF+1 -> result 0, zero=1, carry=1; SLL 16'h0001 by 15 -> 16'h8000, neg=1.
- MUL (MUL_EN): r1=300, r2=300, MUL r3 -> stall high exactly 16 cycles, r3=16'h5F90 (90000 mod 65536), the held dependent instruction executes afterward with the correct operand; repeat with rst during BUSY -> stall=0, r3=0.
